// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory responder: register-array memory behind independent
// read and write channels, one outstanding INCR burst per direction.
module axi4_mem_responder #(
    parameter int ID_WIDTH   = 5,
    parameter int LEN_WIDTH  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_AWIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam logic [MEM_AWIDTH-1:0] IDX_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AWIDTH];

    wstate_t               wstate, wstate_nx;
    logic [ID_WIDTH-1:0]   wid;
    logic [MEM_AWIDTH-1:0] widx;
    logic [LEN_WIDTH-1:0]  wlen, wcnt;
    logic                  werr;
    logic                  aw_fire, w_fire;

    rstate_t               rstate, rstate_nx;
    logic [MEM_AWIDTH-1:0] ridx, ridx_nx;
    logic [LEN_WIDTH-1:0]  rlen, rbeat;

    // Size/burst fields have no effect; only the word-index bits of the addresses matter.
    logic unused_inputs;
    assign unused_inputs = ^{awsize, awburst, arsize, arburst, awaddr, araddr};

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign bid     = wid;
    assign bresp   = (bvalid && werr) ? 2'b10 : 2'b00;
    assign rresp   = 2'b00;
    assign ridx_nx = ridx + IDX_ONE;

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) wstate <= W_IDLE;
        else        wstate <= wstate_nx;
    end

    // Write FSM next state and handshake outputs
    always_comb begin
        wstate_nx = wstate;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (wstate)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) wstate_nx = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) wstate_nx = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    // Write burst tracking; error is sticky once a beat runs past awlen or wlast is early
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wid  <= '0;
            widx <= '0;
            wlen <= '0;
            wcnt <= '0;
            werr <= 1'b0;
        end else if (aw_fire) begin
            wid  <= awid;
            widx <= awaddr[MEM_AWIDTH+OFF-1:OFF];
            wlen <= awlen;
            wcnt <= '0;
            werr <= 1'b0;
        end else if (w_fire) begin
            widx <= widx + IDX_ONE;
            wcnt <= wcnt + CNT_ONE;
            if (wlast ? (wcnt != wlen) : (wcnt == wlen)) werr <= 1'b1;
        end
    end

    // Byte-enabled memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && w_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) rstate <= R_IDLE;
        else        rstate <= rstate_nx;
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        rstate_nx = rstate;
        arready   = 1'b0;
        rvalid    = 1'b0;
        case (rstate)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) rstate_nx = R_FETCH;
            end
            R_FETCH: rstate_nx = R_DATA;
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast) rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    // Read datapath; next beat loads on the accepting edge so beats stream back-to-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rid   <= '0;
            ridx  <= '0;
            rlen  <= '0;
            rbeat <= '0;
            rdata <= '0;
            rlast <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        rid  <= arid;
                        ridx <= araddr[MEM_AWIDTH+OFF-1:OFF];
                        rlen <= arlen;
                    end
                end
                R_FETCH: begin
                    rdata <= mem[ridx];
                    rlast <= (rlen == '0);
                    rbeat <= '0;
                end
                R_DATA: begin
                    if (rready && !rlast) begin
                        ridx  <= ridx_nx;
                        rdata <= mem[ridx_nx];
                        rbeat <= rbeat + CNT_ONE;
                        rlast <= ((rbeat + CNT_ONE) == rlen);
                    end else if (rready) begin
                        rlast <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: bursts, strobes, wlast errors,
// index wrap, handshake stalls and mid-burst reset.
module tb_axi4_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] wdat [16];
    logic [7:0]  wstb [16];
    logic [63:0] rd   [16];
    logic [1:0]  resp;
    logic [4:0]  rbid;

    axi4_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input int nbeats, input int last_at, input bit bstall,
                             output logic [1:0] r, output logic [4:0] b_id);
        int cyc;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1; cyc = 0;
        while (!awready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("aw_wait", 64'(cyc < 50), 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wdat[i]; wstrb = wstb[i]; wlast = (i == last_at); wvalid = 1'b1; cyc = 0;
            while (!wready && cyc < 50) begin @(posedge clk); #1; cyc++; end
            check("w_wait", 64'(cyc < 50), 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; cyc = 0;
        while (!bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("b_wait", 64'(cyc < 50), 1);
        if (bstall) begin
            for (int s = 0; s < 3; s++) begin
                @(posedge clk); #1;
                check("b_hold", bvalid, 1);
            end
        end
        r = bresp; b_id = bid; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("b_done", {bvalid, awready}, 2'b01);
    endtask

    task automatic axi_read(input logic [4:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input bit stall, input bit lat);
        int          cyc;
        int          n;
        logic [63:0] held;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1; cyc = 0;
        while (!arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("ar_wait", 64'(cyc < 50), 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (lat) begin
            check("r_lat_fetch", rvalid, 0);
            @(posedge clk); #1;
            check("r_lat_first", rvalid, 1);
        end
        for (int b = 0; b <= int'(len); b++) begin
            cyc = 0;
            while (!rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
            check("r_wait", 64'(cyc < 50), 1);
            if (!stall && b > 0) check("r_b2b", cyc, 0);
            if (stall) begin
                held = rdata;
                n = $urandom_range(1, 3);
                for (int s = 0; s < n; s++) begin
                    @(posedge clk); #1;
                    check("r_hold_vld", rvalid, 1);
                    check("r_hold_data", rdata, held);
                end
            end
            rd[b] = rdata;
            check("r_last", rlast, 64'(b == int'(len)));
            check("r_id", rid, id);
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
        check("r_done", rvalid, 0);
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bresp", bresp, 0);
        check("rst_bid", bid, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;

        // single beat write + read with latency check
        wdat[0] = 64'h0000_0000_DEAD_BEEF; wstb[0] = 8'hFF;
        axi_write(5'd3, 32'h40, 4'd0, 1, 0, 1'b0, resp, rbid);
        check("t1_bid", rbid, 3);
        check("t1_bresp", resp, 0);
        axi_read(5'd7, 32'h40, 4'd0, 1'b0, 1'b1);
        check("t1_rdata", rd[0], 64'h0000_0000_DEAD_BEEF);

        // 16-beat burst, back-to-back readback
        for (int i = 0; i < 16; i++) begin wdat[i] = 64'(i); wstb[i] = 8'hFF; end
        axi_write(5'd1, 32'h0, 4'd15, 16, 15, 1'b0, resp, rbid);
        check("t2_bresp", resp, 0);
        axi_read(5'd2, 32'h0, 4'd15, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) check("t2_rdata", rd[i], 64'(i));

        // partial strobe
        wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
        axi_write(5'd4, 32'h80, 4'd0, 1, 0, 1'b0, resp, rbid);
        wdat[0] = 64'h1122_3344_5566_7788; wstb[0] = 8'h0F;
        axi_write(5'd4, 32'h80, 4'd0, 1, 0, 1'b0, resp, rbid);
        axi_read(5'd4, 32'h80, 4'd0, 1'b0, 1'b0);
        check("t3_strobe", rd[0], 64'hFFFF_FFFF_5566_7788);

        // wlast error cases, then a clean burst
        wstb[0] = 8'hFF; wstb[1] = 8'hFF;
        axi_write(5'd5, 32'h100, 4'd3, 2, 1, 1'b0, resp, rbid);
        check("t4_early_bresp", resp, 2'b10);
        axi_write(5'd6, 32'h100, 4'd0, 2, 1, 1'b0, resp, rbid);
        check("t4_late_bresp", resp, 2'b10);
        axi_write(5'd5, 32'h100, 4'd1, 2, 1, 1'b0, resp, rbid);
        check("t4_ok_bresp", resp, 2'b00);
        check("t4_ok_bid", rbid, 5);

        // wrap across top of memory with B and R stalls
        for (int i = 0; i < 4; i++) begin wdat[i] = 64'hA0 + 64'(i); wstb[i] = 8'hFF; end
        axi_write(5'd8, 32'h1FF0, 4'd3, 4, 3, 1'b1, resp, rbid);
        check("t5_bresp", resp, 0);
        axi_read(5'd9, 32'h1FF0, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) check("t5_rdata", rd[i], 64'hA0 + 64'(i));
        axi_read(5'd9, 32'h0, 4'd1, 1'b1, 1'b0);
        check("t5_wrap_w0", rd[0], 64'hA2);
        check("t5_wrap_w1", rd[1], 64'hA3);

        // low address bits ignored
        axi_read(5'd11, 32'h47, 4'd0, 1'b0, 1'b0);
        check("t5_lowbits", rd[0], 64'd8);

        // reset during beat 2 of an 8-beat read
        arid = 5'd12; araddr = 32'h0; arlen = 4'd7; arvalid = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (!arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
            @(posedge clk); #1;
            arvalid = 1'b0;
            for (int b = 0; b < 3; b++) begin
                cyc = 0;
                while (!rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
                check("t6_beat_wait", 64'(cyc < 50), 1);
                if (b < 2) begin
                    rready = 1'b1;
                    @(posedge clk); #1;
                    rready = 1'b0;
                end
            end
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rvalid", rvalid, 0);
        check("t6_arready", arready, 1);
        check("t6_awready", awready, 1);
        check("t6_rdata", rdata, 0);
        rst_n = 1'b1;
        axi_read(5'd10, 32'h40, 4'd0, 1'b0, 1'b1);
        check("t6_after_rdata", rd[0], 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
